// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage for the Monociclo RV32I core. Owns the PC, issues single-word
// instruction-memory reads with a req/ack handshake, latches the returned
// word and presents it (with OpCode/Funct3/Funct7 slices) to decode. When the
// presented instruction retires the PC either advances by 4 or takes the
// branch/jump redirect from execute. A misaligned redirect target or an
// instruction-memory timeout parks the unit in HALT until reset.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   Stall          hold the presented instruction, block retirement
//   BranchTaken    redirect request for the presented instruction
//   BranchTarget   redirect target (ALU result), LSB cleared as for JALR
//   IMemReq        instruction-memory read request
//   IMemAddr       request address (= PC)
//   IMemAck        memory response valid, sampled only while IMemReq=1
//   IMemRData      instruction word, valid with IMemAck
//   Instr          latched instruction (NOP_INSTR when InstrValid=0)
//   OpCode/Funct3/Funct7  slices of Instr
//   PC, PCPlus4    address of Instr and its link value
//   InstrValid     Instr holds a fetched word for decode
//   ErrMisalign    sticky: redirect target not 4-byte aligned
//   ErrTimeout     sticky: IMemAck not seen within TIMEOUT cycles
//   RetireCount    number of retired instructions (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic [6:0]  OpCode,
  output logic [2:0]  Funct3,
  output logic [6:0]  Funct7,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  output logic        ErrMisalign,
  output logic        ErrTimeout,
  output logic [31:0] RetireCount
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [31:0]         r_pc;
  logic [31:0]         r_instr;
  logic                r_valid;
  logic                r_err_misalign;
  logic                r_err_timeout;
  logic [31:0]         r_retire_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic                w_req;
  logic                w_load_instr;
  logic                w_wait_inc;
  logic                w_timeout;
  logic                w_retire;
  logic                w_misalign;
  logic [31:0]         w_target;
  logic [31:0]         w_pc_plus4;
  logic [31:0]         w_next_pc;
  logic                w_unused_target_lsb;

  // JALR semantics: bit 0 of the target is always discarded, so only bit 1
  // can make the target misaligned.
  assign w_target            = {BranchTarget[31:1], 1'b0};
  assign w_unused_target_lsb = BranchTarget[0];
  assign w_pc_plus4          = r_pc + 32'd4;
  assign w_next_pc           = BranchTaken ? w_target : w_pc_plus4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_load_instr = 1'b0;
    w_wait_inc   = 1'b0;
    w_timeout    = 1'b0;
    w_retire     = 1'b0;
    w_misalign   = 1'b0;

    unique case (r_state)
      S_BOOT: begin
        w_next_state = S_FETCH;
      end

      S_FETCH: begin
        w_req = 1'b1;
        if (IMemAck) begin
          w_load_instr = 1'b1;
          w_next_state = S_EXEC;
        end else if (r_wait_cnt == WAIT_LAST) begin
          // This is the TIMEOUT-th cycle spent waiting without an ack.
          w_timeout    = 1'b1;
          w_next_state = S_HALT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end

      S_EXEC: begin
        if (!Stall) begin
          w_retire = 1'b1;
          if (BranchTaken && w_target[1]) begin
            w_misalign   = 1'b1;
            w_next_state = S_HALT;
          end else begin
            w_next_state = S_FETCH;
          end
        end
      end

      S_HALT: begin
        w_next_state = S_HALT;
      end

      default: begin
        w_next_state = S_BOOT;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_instr        <= NOP_INSTR;
      r_valid        <= 1'b0;
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_retire_cnt   <= '0;
      r_wait_cnt     <= '0;
    end else begin
      if (w_load_instr) begin
        r_instr    <= IMemRData;
        r_valid    <= 1'b1;
        r_wait_cnt <= '0;
      end

      if (w_wait_inc) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end

      // A misaligned redirect still retires the instruction but leaves the
      // PC pointing at it, so the faulting address stays visible.
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
        r_valid      <= 1'b0;
        r_instr      <= NOP_INSTR;
        if (w_misalign) begin
          r_err_misalign <= 1'b1;
        end else begin
          r_pc <= w_next_pc;
        end
      end
    end
  end

  assign IMemReq     = w_req;
  assign IMemAddr    = r_pc;
  assign Instr       = r_instr;
  assign OpCode      = r_instr[6:0];
  assign Funct3      = r_instr[14:12];
  assign Funct7      = r_instr[31:25];
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign InstrValid  = r_valid;
  assign ErrMisalign = r_err_misalign;
  assign ErrTimeout  = r_err_timeout;
  assign RetireCount = r_retire_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. Inputs are driven and outputs
// sampled on the falling clock edge. Directed scenarios cover boot, wait
// states, redirect, stall, faults, reset during fetch and PC wrap; a
// randomized run is checked against a transaction-level model that tracks
// only the expected PC, presented word and retirement count.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned TO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic [31:0] Instr;
  logic [6:0]  OpCode;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic        ErrMisalign;
  logic        ErrTimeout;
  logic [31:0] RetireCount;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .TIMEOUT   (TO),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemRData    (IMemRData),
    .Instr        (Instr),
    .OpCode       (OpCode),
    .Funct3       (Funct3),
    .Funct7       (Funct7),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .InstrValid   (InstrValid),
    .ErrMisalign  (ErrMisalign),
    .ErrTimeout   (ErrTimeout),
    .RetireCount  (RetireCount)
  );

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the DUT in its BOOT cycle, at a falling edge.
  task automatic do_reset();
    rst          = 1'b1;
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = '0;
    IMemAck      = 1'b0;
    IMemRData    = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Memory side of one fetch: waits (bounded) for a request, withholds the
  // ack for 'delay' cycles, then returns 'word'. Ends in the presenting cycle.
  task automatic serve(input int unsigned delay, input logic [31:0] word,
                       output bit got_req, output logic [31:0] addr,
                       output bit stable);
    got_req = 1'b0;
    stable  = 1'b1;
    addr    = '0;
    for (int i = 0; i < 8; i++) begin
      if (IMemReq === 1'b1) begin
        got_req = 1'b1;
        break;
      end
      step();
    end
    if (!got_req) return;
    addr = IMemAddr;
    for (int unsigned k = 0; k < delay; k++) begin
      IMemAck   = 1'b0;
      IMemRData = $urandom;
      step();
      if (IMemReq !== 1'b1 || IMemAddr !== addr) stable = 1'b0;
    end
    IMemAck   = 1'b1;
    IMemRData = word;
    step();
    IMemAck   = 1'b0;
    IMemRData = $urandom;
  endtask

  task automatic retire(input logic br, input logic [31:0] tgt);
    Stall        = 1'b0;
    BranchTaken  = br;
    BranchTarget = tgt;
    step();
    BranchTaken  = 1'b0;
    BranchTarget = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    IMemAck = 1'b0; IMemRData = '0;
    step();
    n_checks++; if (IMemReq !== 1'b0) $display("FAIL reset_req: got %b exp 0", IMemReq); else n_pass++;
    n_checks++; if (PC !== 32'h0) $display("FAIL reset_pc: got %h exp 00000000", PC); else n_pass++;
    n_checks++; if (Instr !== NOP) $display("FAIL reset_instr: got %h exp %h", Instr, NOP); else n_pass++;
    n_checks++; if (InstrValid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", InstrValid); else n_pass++;
    n_checks++; if (ErrMisalign !== 1'b0 || ErrTimeout !== 1'b0)
      $display("FAIL reset_err: got mis=%b to=%b exp 0 0", ErrMisalign, ErrTimeout); else n_pass++;
    n_checks++; if (RetireCount !== 32'h0) $display("FAIL reset_retire: got %0d exp 0", RetireCount); else n_pass++;
    step();
    rst = 1'b0; IMemAck = 1'b1; IMemRData = 32'h0050_0093;
    n_checks++; if (IMemReq !== 1'b0) $display("FAIL boot_req: got %b exp 0", IMemReq); else n_pass++;
    step();
    n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0)
      $display("FAIL boot_fetch: got req=%b addr=%h exp 1 00000000", IMemReq, IMemAddr); else n_pass++;
    step();
    IMemAck = 1'b0;
    n_checks++; if (InstrValid !== 1'b1) $display("FAIL boot_valid: got %b exp 1", InstrValid); else n_pass++;
    n_checks++; if (Instr !== 32'h0050_0093) $display("FAIL boot_instr: got %h exp 00500093", Instr); else n_pass++;
    n_checks++; if (OpCode !== 7'b0010011 || Funct3 !== 3'b000 || Funct7 !== 7'b0)
      $display("FAIL boot_slices: got op=%b f3=%b f7=%b exp 0010011 000 0000000", OpCode, Funct3, Funct7); else n_pass++;
    n_checks++; if (PC !== 32'h0 || PCPlus4 !== 32'h4)
      $display("FAIL boot_pc: got pc=%h pc4=%h exp 0 4", PC, PCPlus4); else n_pass++;
    n_checks++; if (IMemReq !== 1'b0) $display("FAIL boot_exec_req: got %b exp 0", IMemReq); else n_pass++;
  endtask

  task automatic test_sequential();
    bit got; bit stable; logic [31:0] addr;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      logic [31:0] a = 32'(4 * n);
      serve(3, mem_word(a), got, addr, stable);
      n_checks++; if (!got || addr !== a)
        $display("FAIL seq_addr%0d: got req=%b addr=%h exp 1 %h", n, got, addr, a); else n_pass++;
      n_checks++; if (!stable) $display("FAIL seq_stable%0d: got unstable exp stable", n); else n_pass++;
      n_checks++; if (InstrValid !== 1'b1 || Instr !== mem_word(a) || PC !== a)
        $display("FAIL seq_instr%0d: got v=%b i=%h pc=%h exp 1 %h %h", n, InstrValid, Instr, PC, mem_word(a), a);
      else n_pass++;
      retire(1'b0, 32'h0);
    end
    n_checks++; if (RetireCount !== 32'd3) $display("FAIL seq_retire: got %0d exp 3", RetireCount); else n_pass++;
    n_checks++; if (IMemAddr !== 32'hC) $display("FAIL seq_next: got %h exp 0000000c", IMemAddr); else n_pass++;
  endtask

  task automatic test_redirect();
    bit got; bit stable; logic [31:0] addr;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      serve(1, mem_word(32'(4 * n)), got, addr, stable);
      retire(1'b0, 32'h0);
    end
    serve(0, mem_word(32'h8), got, addr, stable);
    n_checks++; if (PC !== 32'h8) $display("FAIL redir_pc: got %h exp 00000008", PC); else n_pass++;
    retire(1'b1, 32'h0000_0041);
    n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h40)
      $display("FAIL redir_addr: got req=%b addr=%h exp 1 00000040", IMemReq, IMemAddr); else n_pass++;
    n_checks++; if (RetireCount !== 32'd3) $display("FAIL redir_retire: got %0d exp 3", RetireCount); else n_pass++;
    n_checks++; if (ErrMisalign !== 1'b0) $display("FAIL redir_err: got %b exp 0", ErrMisalign); else n_pass++;
    serve(0, mem_word(32'h40), got, addr, stable);
    n_checks++; if (Instr !== mem_word(32'h40) || PC !== 32'h40)
      $display("FAIL redir_instr: got i=%h pc=%h exp %h 00000040", Instr, PC, mem_word(32'h40)); else n_pass++;
  endtask

  task automatic test_stall();
    bit got; bit stable; logic [31:0] addr; logic [31:0] w;
    do_reset();
    w = mem_word(32'h0);
    serve(2, w, got, addr, stable);
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      BranchTaken  = i[0];
      BranchTarget = $urandom;
      IMemAck      = 1'(($urandom));
      IMemRData    = $urandom;
      step();
      n_checks++; if (Instr !== w || PC !== 32'h0 || InstrValid !== 1'b1)
        $display("FAIL stall_hold%0d: got i=%h pc=%h v=%b exp %h 0 1", i, Instr, PC, InstrValid, w); else n_pass++;
      n_checks++; if (IMemReq !== 1'b0 || RetireCount !== 32'd0)
        $display("FAIL stall_idle%0d: got req=%b ret=%0d exp 0 0", i, IMemReq, RetireCount); else n_pass++;
    end
    IMemAck = 1'b0;
    retire(1'b0, $urandom);
    n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h4 || RetireCount !== 32'd1)
      $display("FAIL stall_release: got req=%b addr=%h ret=%0d exp 1 4 1", IMemReq, IMemAddr, RetireCount); else n_pass++;
  endtask

  task automatic test_misalign();
    bit got; bit stable; logic [31:0] addr;
    do_reset();
    serve(0, mem_word(32'h0), got, addr, stable);
    retire(1'b1, 32'h0000_0022);
    n_checks++; if (ErrMisalign !== 1'b1) $display("FAIL mis_flag: got %b exp 1", ErrMisalign); else n_pass++;
    n_checks++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || Instr !== NOP)
      $display("FAIL mis_halt: got req=%b v=%b i=%h exp 0 0 %h", IMemReq, InstrValid, Instr, NOP); else n_pass++;
    n_checks++; if (PC !== 32'h0 || RetireCount !== 32'd1)
      $display("FAIL mis_state: got pc=%h ret=%0d exp 0 1", PC, RetireCount); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      Stall = 1'($urandom); BranchTaken = 1'($urandom); BranchTarget = $urandom;
      IMemAck = 1'b1; IMemRData = $urandom;
      step();
      n_checks++; if (IMemReq !== 1'b0 || ErrMisalign !== 1'b1 || PC !== 32'h0 || RetireCount !== 32'd1)
        $display("FAIL mis_frozen%0d: got req=%b err=%b pc=%h ret=%0d exp 0 1 0 1",
                 i, IMemReq, ErrMisalign, PC, RetireCount); else n_pass++;
    end
    rst = 1'b1; IMemAck = 1'b0;
    step();
    rst = 1'b0;
    n_checks++; if (ErrMisalign !== 1'b0) $display("FAIL mis_clear: got %b exp 0", ErrMisalign); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    step();
    for (int i = 0; i < int'(TO) - 1; i++) step();
    n_checks++; if (ErrTimeout !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h0)
      $display("FAIL to_early: got err=%b req=%b addr=%h exp 0 1 0", ErrTimeout, IMemReq, IMemAddr); else n_pass++;
    step();
    n_checks++; if (ErrTimeout !== 1'b1) $display("FAIL to_flag: got %b exp 1", ErrTimeout); else n_pass++;
    n_checks++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0)
      $display("FAIL to_halt: got req=%b v=%b exp 0 0", IMemReq, InstrValid); else n_pass++;
    IMemAck = 1'b1; IMemRData = $urandom;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || ErrTimeout !== 1'b1)
        $display("FAIL to_frozen%0d: got req=%b v=%b err=%b exp 0 0 1", i, IMemReq, InstrValid, ErrTimeout);
      else n_pass++;
    end
    rst = 1'b1; IMemAck = 1'b0;
    step();
    rst = 1'b0;
    n_checks++; if (ErrTimeout !== 1'b0) $display("FAIL to_clear: got %b exp 0", ErrTimeout); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    bit got; bit stable; logic [31:0] addr;
    do_reset();
    serve(0, mem_word(32'h0), got, addr, stable);
    retire(1'b0, 32'h0);
    n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h4)
      $display("FAIL rmf_pre: got req=%b addr=%h exp 1 4", IMemReq, IMemAddr); else n_pass++;
    rst = 1'b1; IMemAck = 1'b1; IMemRData = 32'hDEAD_BEEF;
    step();
    n_checks++; if (IMemReq !== 1'b0 || PC !== 32'h0 || Instr !== NOP || InstrValid !== 1'b0)
      $display("FAIL rmf_reset: got req=%b pc=%h i=%h v=%b exp 0 0 %h 0", IMemReq, PC, Instr, InstrValid, NOP);
    else n_pass++;
    n_checks++; if (RetireCount !== 32'd0 || ErrMisalign !== 1'b0 || ErrTimeout !== 1'b0)
      $display("FAIL rmf_cnt: got ret=%0d mis=%b to=%b exp 0 0 0", RetireCount, ErrMisalign, ErrTimeout); else n_pass++;
    rst = 1'b0; IMemAck = 1'b0;
    step();
    n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0 || InstrValid !== 1'b0 || Instr !== NOP)
      $display("FAIL rmf_refetch: got req=%b addr=%h v=%b i=%h exp 1 0 0 %h", IMemReq, IMemAddr, InstrValid, Instr, NOP);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    bit got; bit stable; logic [31:0] addr;
    do_reset();
    serve(0, mem_word(32'h0), got, addr, stable);
    retire(1'b1, 32'hFFFF_FFFD);
    n_checks++; if (IMemAddr !== 32'hFFFF_FFFC || ErrMisalign !== 1'b0)
      $display("FAIL wrap_target: got addr=%h err=%b exp fffffffc 0", IMemAddr, ErrMisalign); else n_pass++;
    serve(1, mem_word(32'hFFFF_FFFC), got, addr, stable);
    n_checks++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0)
      $display("FAIL wrap_pc4: got pc=%h pc4=%h exp fffffffc 0", PC, PCPlus4); else n_pass++;
    retire(1'b0, 32'h0);
    n_checks++; if (IMemAddr !== 32'h0 || RetireCount !== 32'd2)
      $display("FAIL wrap_next: got addr=%h ret=%0d exp 0 2", IMemAddr, RetireCount); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc    = 32'h0;
    logic [31:0] exp_ret   = 32'h0;
    logic [31:0] exp_instr = NOP;
    logic [31:0] tgt;
    bit presenting = 1'b0;
    int unsigned wait_cnt = 0;
    int unsigned delay    = $urandom_range(0, 4);
    do_reset();
    step();
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++; if (RetireCount !== exp_ret)
        $display("FAIL rnd_retire@%0d: got %0d exp %0d", cyc, RetireCount, exp_ret); else n_pass++;
      if (presenting) begin
        n_checks++; if (InstrValid !== 1'b1 || Instr !== exp_instr || PC !== exp_pc || IMemReq !== 1'b0)
          $display("FAIL rnd_exec@%0d: got v=%b i=%h pc=%h req=%b exp 1 %h %h 0",
                   cyc, InstrValid, Instr, PC, IMemReq, exp_instr, exp_pc); else n_pass++;
        n_checks++; if (OpCode !== exp_instr[6:0] || Funct3 !== exp_instr[14:12] ||
                        Funct7 !== exp_instr[31:25] || PCPlus4 !== exp_pc + 32'd4)
          $display("FAIL rnd_decode@%0d: got op=%h f3=%h f7=%h pc4=%h", cyc, OpCode, Funct3, Funct7, PCPlus4);
        else n_pass++;
      end else begin
        n_checks++; if (IMemReq !== 1'b1 || IMemAddr !== exp_pc || InstrValid !== 1'b0 || Instr !== NOP)
          $display("FAIL rnd_fetch@%0d: got req=%b addr=%h v=%b i=%h exp 1 %h 0 %h",
                   cyc, IMemReq, IMemAddr, InstrValid, Instr, exp_pc, NOP); else n_pass++;
      end
      n_checks++; if (ErrMisalign !== 1'b0 || ErrTimeout !== 1'b0)
        $display("FAIL rnd_err@%0d: got mis=%b to=%b exp 0 0", cyc, ErrMisalign, ErrTimeout); else n_pass++;

      if (presenting) begin
        Stall        = ($urandom_range(0, 2) == 0);
        BranchTaken  = 1'($urandom);
        tgt          = $urandom;
        tgt[1]       = 1'b0;
        BranchTarget = tgt;
        IMemAck      = 1'($urandom);
        IMemRData    = $urandom;
        if (!Stall) begin
          exp_ret    = exp_ret + 32'd1;
          exp_pc     = BranchTaken ? {tgt[31:1], 1'b0} : exp_pc + 32'd4;
          presenting = 1'b0;
          wait_cnt   = 0;
          delay      = $urandom_range(0, 4);
        end
      end else begin
        Stall        = 1'($urandom);
        BranchTaken  = 1'($urandom);
        BranchTarget = $urandom;
        if (wait_cnt == delay) begin
          exp_instr  = mem_word(exp_pc);
          IMemAck    = 1'b1;
          IMemRData  = exp_instr;
          presenting = 1'b1;
        end else begin
          IMemAck   = 1'b0;
          IMemRData = $urandom;
          wait_cnt++;
        end
      end
      step();
    end
    IMemAck = 1'b0;
    Stall   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_misalign();
    test_timeout();
    test_reset_mid_fetch();
    test_pc_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the decoder/control unit in the Monociclo RV32I core.
- Holds the PC and issues instruction-memory reads with a req/ack handshake.
- Latches the returned word and presents it, with OpCode/Funct3/Funct7 slices, to decode.
- Applies the branch/jump redirect from the execute side once the presented instruction retires.
- Detects misaligned targets and memory timeouts.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, max cycles waiting for IMemAck before fault (>=1).
NOP_INSTR, 32'h0000_0013, value of Instr whenever InstrValid=0 (addi x0,x0,0).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
Stall  input  1  hold presented instruction, block retirement
BranchTaken  input  1  redirect request for the presented instruction
BranchTarget  input  32  redirect target (ALU result)
IMemReq  output  1  instruction-memory read request
IMemAddr  output  32  word address of request (= PC)
IMemAck  input  1  memory response valid; sampled only while IMemReq=1
IMemRData  input  32  instruction word, valid with IMemAck
Instr  output  32  latched instruction
OpCode  output  7  Instr[6:0]
Funct3  output  3  Instr[14:12]
Funct7  output  7  Instr[31:25]
PC  output  32  address of Instr
PCPlus4  output  32  PC+4, used as link value for JAL/JALR
InstrValid  output  1  Instr holds a fetched word for decode
ErrMisalign  output  1  sticky: redirect target not 4-byte aligned
ErrTimeout  output  1  sticky: IMemAck not seen within TIMEOUT cycles
RetireCount  output  32  number of retired instructions

Behaviour:
- Reset (rst=1 at edge), regardless of current state or an outstanding request:
  - PC=RESET_PC, Instr=NOP_INSTR, InstrValid=0, IMemReq=0.
  - ErrMisalign=0, ErrTimeout=0, RetireCount=0, wait counter=0, state=BOOT.
  - Any IMemAck arriving after reset is ignored.
- States BOOT, FETCH, EXEC, HALT.
- BOOT: one cycle, IMemReq=0; next state FETCH.
- FETCH:
  - IMemReq=1, IMemAddr=PC, both stable until ack. InstrValid=0, Instr=NOP_INSTR.
  - On IMemAck=1: Instr<=IMemRData, InstrValid<=1, wait counter<=0, next EXEC.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT-1 without ack, ErrTimeout<=1 and next HALT.
  - Minimum latency: request cycle to InstrValid=1 is 1 cycle when ack comes in the request cycle.
- EXEC:
  - IMemReq=0; Instr, PC and InstrValid held.
  - Stall=1: hold everything. BranchTaken and BranchTarget are ignored.
  - Stall=0: instruction retires. RetireCount<=RetireCount+1 (wraps at 2^32). InstrValid<=0, Instr<=NOP_INSTR, next FETCH.
    - BranchTaken=0: PC<=PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
    - BranchTaken=1: t={BranchTarget[31:1],1'b0} (JALR LSB clear).
      - t[1]=0: PC<=t.
      - t[1]=1: ErrMisalign<=1, PC unchanged, InstrValid<=0, next HALT. The faulting instruction still counts as retired.
- HALT: IMemReq=0, InstrValid=0, all registers frozen; exit only via rst.
- PCPlus4 is combinational PC+4. OpCode/Funct3/Funct7 are combinational slices of Instr (a NOP when not valid).
- IMemAck outside FETCH is ignored.

Test Plan:
- Reset/boot: rst high 2 cycles, then low; memory acks immediately with 32'h00500093 → cycle after rst low IMemReq=0; next cycle IMemReq=1, IMemAddr=0; following cycle InstrValid=1, OpCode=7'b0010011, PC=0, PCPlus4=4.
- Sequential fetch with wait states: ack delayed 3 cycles per fetch, Stall=0, no branches → IMemAddr 0,4,8 stable throughout each wait; RetireCount=3 after third retirement.
- Redirect: at PC=8, BranchTaken=1, BranchTarget=32'h0000_0041 → next IMemAddr=32'h40, RetireCount +1, ErrMisalign=0.
- Stall: hold Stall=1 for 5 cycles in EXEC with BranchTaken=1 toggling → Instr/PC unchanged, no IMemReq, RetireCount unchanged; release Stall with BranchTaken=0 → next address PC+4.
- Faults:
  - BranchTarget=32'h0000_0022 → ErrMisalign=1, HALT, IMemReq stays 0.
  - Separately, withhold ack for TIMEOUT=16 cycles → ErrTimeout=1 after the 16th waiting cycle, HALT.
  - Assert rst mid-FETCH with an ack arriving the same cycle → ack ignored, all outputs at reset values.
